// File: rtl/ppm_slot_decoder.sv
// PPM 1-of-4 slot decoder: samples the line once per divided-clock slot, assembles
// dibits LSB-first into bytes and flags start/end of frame and coding errors.
module ppm_slot_decoder #(
  parameter int unsigned BYTE_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_16_in,
  input  logic                  ppm_in,
  output logic [7:0]            data_out,
  output logic                  data_valid,
  output logic                  frame_done,
  output logic                  frame_err,
  output logic                  busy,
  output logic [BYTE_CNT_W-1:0] byte_cnt
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SOF_CHK = 2'd1;
  localparam logic [1:0] DATA    = 2'd2;

  logic [1:0] state_q;
  logic       clk16_d;
  logic       tick;
  logic [1:0] slot_cnt;
  logic [1:0] sym_cnt;
  logic [1:0] pcnt;
  logic [1:0] first_slot;
  logic [7:0] shift;

  logic [1:0] pcnt_inc;
  logic [1:0] dibit;
  logic [7:0] byte_next;

  assign tick = clk_16_in & ~clk16_d;
  assign busy = (state_q != IDLE);

  always_comb begin
    pcnt_inc = pcnt;
    if (ppm_in) begin
      pcnt_inc = (pcnt == 2'd0) ? 2'd1 : 2'd2;
    end
    // With no earlier pulse, the only pulse must be in the current (last) slot.
    dibit = (pcnt == 2'd0) ? slot_cnt : first_slot;
    byte_next = shift;
    byte_next[{sym_cnt, 1'b0} +: 2] = dibit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk16_d    <= 1'b1;
      state_q    <= IDLE;
      slot_cnt   <= 2'd0;
      sym_cnt    <= 2'd0;
      pcnt       <= 2'd0;
      first_slot <= 2'd0;
      shift      <= 8'h00;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      byte_cnt   <= '0;
    end else begin
      clk16_d    <= clk_16_in;
      data_valid <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (tick) begin
        case (state_q)
          IDLE: begin
            if (ppm_in) state_q <= SOF_CHK;
          end
          SOF_CHK: begin
            if (ppm_in) begin
              state_q  <= DATA;
              slot_cnt <= 2'd0;
              sym_cnt  <= 2'd0;
              pcnt     <= 2'd0;
              shift    <= 8'h00;
              byte_cnt <= '0;
            end else begin
              state_q <= IDLE;
            end
          end
          DATA: begin
            slot_cnt <= slot_cnt + 2'd1;
            if (slot_cnt != 2'd3) begin
              if (ppm_in) begin
                if (pcnt == 2'd0) first_slot <= slot_cnt;
                pcnt <= pcnt_inc;
              end
            end else begin
              pcnt <= 2'd0;
              if (pcnt_inc == 2'd1) begin
                shift   <= byte_next;
                sym_cnt <= sym_cnt + 2'd1;
                if (sym_cnt == 2'd3) begin
                  data_out   <= byte_next;
                  data_valid <= 1'b1;
                  if (byte_cnt != '1) byte_cnt <= byte_cnt + 1'b1;
                end
              end else if (pcnt_inc == 2'd0) begin
                if (sym_cnt == 2'd0) frame_done <= 1'b1;
                else                 frame_err  <= 1'b1;
                state_q <= IDLE;
              end else begin
                frame_err <= 1'b1;
                state_q   <= IDLE;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ppm_slot_decoder.sv
// Bench for ppm_slot_decoder: frames are built as byte/symbol lists and the expected
// strobe sequence is derived directly from that list.
module tb_ppm_slot_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_16_in = 1'b0;
  logic       ppm_in = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_done;
  logic       frame_err;
  logic       busy;
  logic [7:0] byte_cnt;

  int n_chk = 0;
  int n_err = 0;

  localparam int EvValid = 32'h100;
  localparam int EvDone  = 32'h200;
  localparam int EvErr   = 32'h300;
  localparam int EvMulti = 32'hF00;

  int         got_ev[$];
  int         exp_ev[$];
  logic [7:0] frame_bytes[$];
  logic [7:0] exp_data = 8'h00;
  int         exp_cnt = 0;

  ppm_slot_decoder #(.BYTE_CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_16_in  (clk_16_in),
    .ppm_in     (ppm_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .busy       (busy),
    .byte_cnt   (byte_cnt)
  );

  always #5 clk = ~clk;

  // Strobe monitor; simultaneous strobes are logged as a distinct bogus event.
  always @(negedge clk) begin
    if (int'(data_valid) + int'(frame_done) + int'(frame_err) > 1) got_ev.push_back(EvMulti);
    else if (data_valid) got_ev.push_back(EvValid | int'(data_out));
    else if (frame_done) got_ev.push_back(EvDone);
    else if (frame_err)  got_ev.push_back(EvErr);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_slot(input bit v);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      clk_16_in = (i >= 8);
      ppm_in    = v;
    end
  endtask

  task automatic send_sym(input logic [3:0] mask);
    for (int i = 0; i < 4; i++) send_slot(mask[i]);
  endtask

  // Sends SOF, frame_bytes, m partial symbols, then either EOF (bad_mask == 0) or bad_mask.
  task automatic run_frame(input string tag, input bit false_sof, input int m,
                           input logic [3:0] bad_mask);
    logic [7:0] b;
    logic [3:0] one = 4'b0001;
    exp_ev.delete();
    got_ev.delete();
    if (false_sof) begin
      send_slot(1'b1);
      send_slot(1'b0);
    end
    send_slot(1'b1);
    send_slot(1'b1);
    foreach (frame_bytes[k]) begin
      b = frame_bytes[k];
      for (int s = 0; s < 4; s++) send_sym(one << b[2*s +: 2]);
      exp_ev.push_back(EvValid | int'(b));
      exp_data = b;
    end
    exp_cnt = frame_bytes.size();
    for (int j = 0; j < m; j++) send_sym(one << $urandom_range(0, 3));
    send_sym(bad_mask);
    if (bad_mask == 4'b0000 && m == 0) exp_ev.push_back(EvDone);
    else exp_ev.push_back(EvErr);
    send_slot(1'b0);
    send_slot(1'b0);
    check_eq({tag, ".ev_count"}, got_ev.size(), exp_ev.size());
    for (int i = 0; i < exp_ev.size(); i++) begin
      if (i < got_ev.size()) check_eq($sformatf("%s.ev%0d", tag, i), got_ev[i], exp_ev[i]);
    end
    check_eq({tag, ".byte_cnt"}, byte_cnt, exp_cnt);
    check_eq({tag, ".data_out"}, data_out, exp_data);
    check_eq({tag, ".busy"}, busy, 1'b0);
  endtask

  function automatic logic [3:0] rand_bad_mask();
    logic [3:0] mk;
    mk = 4'(($urandom_range(0, 10) + 5));
    while ($countones(mk) < 2) mk = 4'($urandom_range(0, 15));
    return mk;
  endfunction

  initial begin
    int nb;
    int kind;
    repeat (3) @(negedge clk);
    check_eq("rst.data_out", data_out, 8'h00);
    check_eq("rst.byte_cnt", byte_cnt, 8'h00);
    check_eq("rst.data_valid", data_valid, 1'b0);
    check_eq("rst.frame_done", frame_done, 1'b0);
    check_eq("rst.frame_err", frame_err, 1'b0);
    check_eq("rst.busy", busy, 1'b0);
    rst_n = 1'b1;
    send_slot(1'b0);
    send_slot(1'b0);

    frame_bytes = '{8'h93};
    run_frame("full", 1'b0, 0, 4'b0000);
    frame_bytes = '{8'h00, 8'hFF};
    run_frame("two", 1'b0, 0, 4'b0000);
    frame_bytes = '{};
    run_frame("dbl", 1'b0, 2, 4'b0110);
    frame_bytes = '{};
    run_frame("eofmid", 1'b0, 2, 4'b0000);
    frame_bytes = '{8'h5A};
    run_frame("falsesof", 1'b1, 0, 4'b0000);

    for (int f = 0; f < 8; f++) begin
      frame_bytes = '{};
      nb = $urandom_range(0, 3);
      for (int k = 0; k < nb; k++) frame_bytes.push_back(8'($urandom));
      kind = $urandom_range(0, 2);
      if (kind == 0)      run_frame($sformatf("rnd%0d", f), ($urandom_range(0, 3) == 0), 0, 4'b0000);
      else if (kind == 1) run_frame($sformatf("rnd%0d", f), 1'b0, $urandom_range(1, 3), 4'b0000);
      else                run_frame($sformatf("rnd%0d", f), 1'b0, $urandom_range(0, 3), rand_bad_mask());
    end

    // Reset mid-byte with the slot clock held high across release.
    frame_bytes = '{8'hC3};
    run_frame("prerst", 1'b0, 0, 4'b0000);
    got_ev.delete();
    send_slot(1'b1);
    send_slot(1'b1);
    send_sym(4'b0010);
    send_sym(4'b1000);
    @(negedge clk);
    clk_16_in = 1'b1;
    ppm_in    = 1'b1;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_eq("mrst.data_out", data_out, 8'h00);
    check_eq("mrst.byte_cnt", byte_cnt, 8'h00);
    check_eq("mrst.busy", busy, 1'b0);
    repeat (6) @(negedge clk);
    check_eq("mrst.no_tick_busy", busy, 1'b0);
    check_eq("mrst.no_strobe", got_ev.size(), 0);
    exp_data = 8'h00;
    frame_bytes = '{8'h93};
    run_frame("postrst", 1'b0, 0, 4'b0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
